// File: rtl/nk_c2_serial_negator_pkg.sv
// Shared constants for the serial two's complement negator: FSM encoding
// and the chunk-counter width helper.
package nk_c2_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  // A single-chunk configuration still needs a 1-bit counter to exist.
  function automatic int cntWidth(input int n, input int k);
    int r;
    r = $clog2(n / k);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/nk_c2_serial_negator_if.sv
// Operand/result handshake bundle between a producer/consumer (master)
// and the serial negator (slave).
interface nk_c2_serial_negator_if #(
  parameter int N = 8
);
  logic [N-1:0] x;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] z;
  logic         ow;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output x, in_valid, out_ready,
    input  in_ready, z, ow, out_valid
  );

  modport slave (
    input  x, in_valid, out_ready,
    output in_ready, z, ow, out_valid
  );
endinterface

// File: rtl/nk_c2_serial_negator_incr.sv
// K-bit chunk of the negation: inverts a and adds the incoming ripple carry.
module n_c2_chunk_incrementer #(
  parameter int K = 2
) (
  input  logic [K-1:0] a,
  input  logic         cin,
  output logic [K-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, ~a} + {{K{1'b0}}, cin};

endmodule

// File: rtl/nk_c2_serial_negator.sv
// Multi-cycle N-bit two's complement negator, K bits per clock LSB first,
// with valid/ready handshakes on both sides.
module nk_c2_serial_negator
  import nk_c2_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 2
) (
  input  logic                        clock,
  input  logic                        reset_,
  nk_c2_serial_negator_if.slave       bus
);

  localparam int CW = cntWidth(N, K);
  localparam logic [CW-1:0] LAST = CW'(N / K - 1);

  if (N < 2 || K < 1 || K > N || (N % K) != 0) begin : g_bad_params
    $error("nk_c2_serial_negator: illegal N/K combination");
  end

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [N-1:0]  op_q, op_d;
  logic [N-1:0]  res_q, res_d;
  logic          xMsb_q, xMsb_d;
  logic [N-1:0]  z_q, z_d;
  logic          ow_q, ow_d;

  logic [K-1:0]  sum;
  logic          cout;
  logic [N-1:0]  resShift;

  n_c2_chunk_incrementer #(.K(K)) u_incr (
    .a    (op_q[K-1:0]),
    .cin  (carry_q),
    .s    (sum),
    .cout (cout)
  );

  // z/ow are only updated on the final chunk so they stay put between results.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    op_d     = op_q;
    res_d    = res_q;
    xMsb_d   = xMsb_q;
    z_d      = z_q;
    ow_d     = ow_q;
    resShift = res_q >> K;
    resShift[N-1 -: K] = sum;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.x;
          xMsb_d  = bus.x[N-1];
          carry_d = 1'b1;
          cnt_d   = '0;
          res_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        op_d    = op_q >> K;
        res_d   = resShift;
        carry_d = cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          z_d     = resShift;
          ow_d    = xMsb_q & resShift[N-1];
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= '0;
      res_q   <= '0;
      xMsb_q  <= 1'b0;
      z_q     <= '0;
      ow_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      op_q    <= op_d;
      res_q   <= res_d;
      xMsb_q  <= xMsb_d;
      z_q     <= z_d;
      ow_q    <= ow_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.z         = z_q;
  assign bus.ow        = ow_q;

endmodule
